gtfmac_wrapper_status_monitor: RTL and testbench

Per-bit status monitor that sits directly downstream of the level syncers in the GTF MAC wrapper. Its inputs are GTF status levels (block lock, link up, rx/tx reset done) that are already synchronized into clk.
- Debounces each bit and emits rise/fall event pulses.
- Keeps sticky latched-high/latched-low flags and saturating transition counters.
- Exposes all of these via a single-cycle clear-on-read handshake to the register block, plus a level interrupt.

---
 rtl/gtfmac_status_mon_pkg.sv | 25 ++
 rtl/gtfmac_wrapper_status_debounce.sv | 98 +++++++++
 rtl/gtfmac_wrapper_status_monitor.sv | 118 +++++++++++
 tb/tb_gtfmac_wrapper_status_monitor.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/gtfmac_status_mon_pkg.sv
// ============================================================================
// Module : gtfmac_status_mon_pkg
// Brief  : Shared types, constants and helpers for the GTF MAC status monitor.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package gtfmac_status_mon_pkg;

  typedef enum logic [0:0] {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } dbnc_state_e;

  localparam int DBNC_MAX_CYCLES = 65535;
  localparam int DCNT_WIDTH      = $clog2(DBNC_MAX_CYCLES + 1);

  function automatic longint unsigned sat_max(input int w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gtfmac_wrapper_status_debounce.sv
// ============================================================================
// Module : gtfmac_wrapper_status_debounce
// Brief  : Single-bit debounce FSM with rise/fall pulse generation.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module gtfmac_wrapper_status_debounce
  import gtfmac_status_mon_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic status_i,
  output logic deb_o,
  output logic rise_o,
  output logic fall_o,
  output logic rise_nxt_o,
  output logic fall_nxt_o
);

  localparam logic [DCNT_WIDTH-1:0] C_LAST = DCNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [DCNT_WIDTH-1:0] C_ONE  = DCNT_WIDTH'(1);

  dbnc_state_e           state_q, state_d;
  logic [DCNT_WIDTH-1:0] dcnt_q, dcnt_d;
  logic                  deb_q, deb_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    deb_d   = deb_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (status_i != deb_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            deb_d  = status_i;
            rise_d = status_i;
            fall_d = !status_i;
          end else begin
            state_d = ST_PENDING;
            dcnt_d  = C_ONE;
          end
        end
      end
      ST_PENDING: begin
        if (status_i == deb_q) begin
          state_d = ST_STABLE;
          dcnt_d  = '0;
        end else if (dcnt_q == C_LAST) begin
          deb_d   = status_i;
          rise_d  = status_i;
          fall_d  = !status_i;
          state_d = ST_STABLE;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + C_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
        dcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_STABLE;
      dcnt_q  <= '0;
      deb_q   <= RESET_VALUE;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      deb_q   <= deb_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign deb_o      = deb_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  // Early strobes let the parent update stickies on the same edge as the pulse.
  assign rise_nxt_o = rise_d;
  assign fall_nxt_o = fall_d;

endmodule

`default_nettype wire

// File: rtl/gtfmac_wrapper_status_monitor.sv
// ============================================================================
// Module : gtfmac_wrapper_status_monitor
// Brief  : Debounced status monitor with stickies, counters, clear-on-read and
//          irq. Counters built only when GTFMAC_STATUS_MON_CNT_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module gtfmac_wrapper_status_monitor
  import gtfmac_status_mon_pkg::*;
#(
  parameter int   WIDTH           = 4,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter int   CNT_WIDTH       = 16,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           status_in,
  output logic [WIDTH-1:0]           status_debounced,
  output logic [WIDTH-1:0]           rise_event,
  output logic [WIDTH-1:0]           fall_event,
  input  logic                       rd_req,
  output logic                       rd_ack,
  output logic [WIDTH-1:0]           rd_latched_high,
  output logic [WIDTH-1:0]           rd_latched_low,
  output logic [WIDTH*CNT_WIDTH-1:0] rd_cnt,
  output logic                       irq
);

  logic [WIDTH-1:0] rise_nxt, fall_nxt;
  logic [WIDTH-1:0] lh_q, lh_d, ll_q, ll_d;
  logic [WIDTH-1:0] rd_lh_q, rd_ll_q;
  logic             rd_ack_q, irq_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gtfmac_wrapper_status_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VALUE     (RESET_VALUE)
    ) u_debounce (
      .clk        (clk),
      .reset      (reset),
      .status_i   (status_in[i]),
      .deb_o      (status_debounced[i]),
      .rise_o     (rise_event[i]),
      .fall_o     (fall_event[i]),
      .rise_nxt_o (rise_nxt[i]),
      .fall_nxt_o (fall_nxt[i])
    );
  end

  // Clear first, then OR in new events, so an event coinciding with a read survives.
  always_comb begin
    lh_d = (rd_req ? '0 : lh_q) | rise_nxt;
    ll_d = (rd_req ? '0 : ll_q) | fall_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lh_q     <= '0;
      ll_q     <= '0;
      rd_lh_q  <= '0;
      rd_ll_q  <= '0;
      rd_ack_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      lh_q     <= lh_d;
      ll_q     <= ll_d;
      rd_ack_q <= rd_req;
      irq_q    <= |(lh_q | ll_q);
      if (rd_req) begin
        rd_lh_q <= lh_q;
        rd_ll_q <= ll_q;
      end
    end
  end

  assign rd_ack          = rd_ack_q;
  assign rd_latched_high = rd_lh_q;
  assign rd_latched_low  = rd_ll_q;
  assign irq             = irq_q;

`ifdef GTFMAC_STATUS_MON_CNT_EN
  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = CNT_WIDTH'(sat_max(CNT_WIDTH));
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_base, rd_cnt_q;

    always_comb begin
      cnt_base = rd_req ? '0 : cnt_q;
      cnt_d    = cnt_base;
      if ((rise_nxt[i] || fall_nxt[i]) && (cnt_base != C_CNT_MAX)) begin
        cnt_d = cnt_base + C_CNT_ONE;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q    <= '0;
        rd_cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
        if (rd_req) begin
          rd_cnt_q <= cnt_q;
        end
      end
    end

    assign rd_cnt[i*CNT_WIDTH +: CNT_WIDTH] = rd_cnt_q;
  end
`else
  assign rd_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gtfmac_wrapper_status_monitor.sv
// ============================================================================
// Module : tb_gtfmac_wrapper_status_monitor
// Brief  : Directed self-checking bench; DUT A default params, DUT B fast/narrow.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_gtfmac_wrapper_status_monitor;

`ifdef GTFMAC_STATUS_MON_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  a_in, a_deb, a_rise, a_fall, a_lh, a_ll;
  logic        a_rd_req, a_rd_ack, a_irq;
  logic [63:0] a_rd_cnt;

  logic [3:0]  b_in, b_deb, b_rise, b_fall, b_lh, b_ll;
  logic        b_rd_req, b_rd_ack, b_irq;
  logic [7:0]  b_rd_cnt;

  logic [3:0]  a_ev;
  int          n_cmp = 0;
  int          n_err = 0;

  gtfmac_wrapper_status_monitor #(
    .WIDTH(4), .DEBOUNCE_CYCLES(16), .CNT_WIDTH(16), .RESET_VALUE(1'b0)
  ) u_dut_a (
    .clk(clk), .reset(reset), .status_in(a_in), .status_debounced(a_deb),
    .rise_event(a_rise), .fall_event(a_fall), .rd_req(a_rd_req), .rd_ack(a_rd_ack),
    .rd_latched_high(a_lh), .rd_latched_low(a_ll), .rd_cnt(a_rd_cnt), .irq(a_irq)
  );

  gtfmac_wrapper_status_monitor #(
    .WIDTH(4), .DEBOUNCE_CYCLES(1), .CNT_WIDTH(2), .RESET_VALUE(1'b0)
  ) u_dut_b (
    .clk(clk), .reset(reset), .status_in(b_in), .status_debounced(b_deb),
    .rise_event(b_rise), .fall_event(b_fall), .rd_req(b_rd_req), .rd_ack(b_rd_ack),
    .rd_latched_high(b_lh), .rd_latched_low(b_ll), .rd_cnt(b_rd_cnt), .irq(b_irq)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      a_ev = a_ev | a_rise | a_fall;
    end
  endtask

  initial begin
    a_in = '0; a_rd_req = 1'b0; b_in = '0; b_rd_req = 1'b0; a_ev = '0;

    // Reset state
    cyc(3);
    chk("rst_deb", 64'(a_deb), 64'h0);
    chk("rst_irq", 64'(a_irq), 64'h0);
    chk("rst_ack", 64'(a_rd_ack), 64'h0);
    reset = 1'b1;

    // Idle after release
    cyc(100);
    chk("idle_events", 64'(a_ev), 64'h0);
    chk("idle_deb", 64'(a_deb), 64'h0);
    chk("idle_irq", 64'(a_irq), 64'h0);

    // Glitch of 15 cycles on bit0
    a_in[0] = 1'b1;
    cyc(15);
    a_in[0] = 1'b0;
    cyc(5);
    chk("glitch_events", 64'(a_ev), 64'h0);
    chk("glitch_deb", 64'(a_deb), 64'h0);

    // Clean rise on bit1: flips on 16th edge
    a_in[1] = 1'b1;
    cyc(15);
    chk("rise_pre_deb", 64'(a_deb), 64'h0);
    chk("rise_pre_evt", 64'(a_rise), 64'h0);
    cyc(1);
    chk("rise_evt", 64'(a_rise), 64'h2);
    chk("rise_deb", 64'(a_deb), 64'h2);
    chk("rise_irq_same", 64'(a_irq), 64'h0);
    cyc(1);
    chk("rise_evt_gone", 64'(a_rise), 64'h0);
    chk("rise_irq_next", 64'(a_irq), 64'h1);

    // First read
    a_rd_req = 1'b1;
    cyc(1);
    a_rd_req = 1'b0;
    chk("rd1_ack", 64'(a_rd_ack), 64'h1);
    chk("rd1_lh", 64'(a_lh), 64'h2);
    chk("rd1_ll", 64'(a_ll), 64'h0);
    chk("rd1_cnt1", 64'(a_rd_cnt[31:16]), CNT_EN ? 64'h1 : 64'h0);
    chk("rd1_cnt0", 64'(a_rd_cnt[15:0]), 64'h0);
    cyc(1);
    chk("rd1_ack_low", 64'(a_rd_ack), 64'h0);
    chk("rd1_hold_lh", 64'(a_lh), 64'h2);
    chk("rd1_irq_clr", 64'(a_irq), 64'h0);

    // Second read returns zeros
    a_rd_req = 1'b1;
    cyc(1);
    a_rd_req = 1'b0;
    chk("rd2_ack", 64'(a_rd_ack), 64'h1);
    chk("rd2_lh", 64'(a_lh), 64'h0);
    chk("rd2_cnt", a_rd_cnt, 64'h0);
    chk("rd2_irq", 64'(a_irq), 64'h0);

    // Collision: read on the same edge as fall of bit1
    a_in[1] = 1'b0;
    cyc(14);
    chk("col_pre_deb", 64'(a_deb), 64'h2);
    a_rd_req = 1'b1;
    cyc(1);
    chk("col_pre_deb2", 64'(a_deb), 64'h2);
    cyc(1);
    a_rd_req = 1'b0;
    chk("col_fall", 64'(a_fall), 64'h2);
    chk("col_deb", 64'(a_deb), 64'h0);
    chk("col_ll", 64'(a_ll), 64'h0);
    chk("col_cnt", a_rd_cnt, 64'h0);
    cyc(1);
    chk("col_irq", 64'(a_irq), 64'h1);
    a_rd_req = 1'b1;
    cyc(1);
    a_rd_req = 1'b0;
    chk("col_rd_ll", 64'(a_ll), 64'h2);
    chk("col_rd_lh", 64'(a_lh), 64'h0);
    chk("col_rd_cnt1", 64'(a_rd_cnt[31:16]), CNT_EN ? 64'h1 : 64'h0);

    // DUT B: single-cycle debounce, 2-bit saturating counter
    b_in[2] = 1'b1;
    cyc(1);
    chk("b_rise", 64'(b_rise), 64'h4);
    chk("b_deb", 64'(b_deb), 64'h4);
    for (int t = 0; t < 5; t++) begin
      b_in[2] = ~b_in[2];
      cyc(1);
    end
    chk("b_deb_final", 64'(b_deb), 64'h0);
    b_rd_req = 1'b1;
    cyc(1);
    b_rd_req = 1'b0;
    chk("b_ack", 64'(b_rd_ack), 64'h1);
    chk("b_lh", 64'(b_lh), 64'h4);
    chk("b_ll", 64'(b_ll), 64'h4);
    chk("b_cnt_sat", 64'(b_rd_cnt), CNT_EN ? 64'h30 : 64'h0);

    // Reset mid-debounce discards pending count
    a_in[3] = 1'b1;
    cyc(10);
    reset = 1'b0;
    cyc(2);
    chk("mid_rst_deb", 64'(a_deb), 64'h0);
    reset = 1'b1;
    cyc(15);
    chk("mid_rst_pend", 64'(a_deb), 64'h0);
    cyc(1);
    chk("mid_rst_flip", 64'(a_deb), 64'h8);
    chk("mid_rst_rise", 64'(a_rise), 64'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
